// File: rtl/serial_rx_8bit.sv
// serial_rx_8bit: 8N1 serial receiver with selectable bit order, one sample per bit at mid-cell.
// A falling edge on the synchronized line starts a frame; the stop-bit sample returns to IDLE.
module serial_rx_8bit #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    input  logic       msb_first,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      idx;
    logic [7:0]      sh;
    logic            msb;
    logic            rx_meta;
    logic            rxs;
    logic            sample;

    // START samples half a bit in; later states sample one full bit after the previous sample
    assign sample = cnt == (state == START ? HALF_END : BIT_END);
    assign busy   = state != IDLE;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta    <= 1'b1;
            rxs        <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            sh         <= '0;
            msb        <= 1'b0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx_in;
            rxs        <= rx_meta;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            cnt        <= sample ? '0 : cnt + CW'(1);
            case (state)
                IDLE: if (!rxs) begin
                    cnt   <= '0;
                    msb   <= msb_first;
                    state <= START;
                end
                START: if (sample) begin
                    idx   <= '0;
                    state <= rxs ? IDLE : DATA;
                end
                DATA: if (sample) begin
                    sh  <= msb ? {sh[6:0], rxs} : {rxs, sh[7:1]};
                    idx <= idx + 3'd1;
                    if (idx == 3'd7) state <= STOP;
                end
                STOP: if (sample) begin
                    if (rxs) begin
                        data_out   <= sh;
                        data_valid <= 1'b1;
                    end else begin
                        frame_err  <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/serial_rx_8bit.md
Name: serial_rx_8bit

Overview:
- Serial-in/parallel-out byte receiver: the receive-side counterpart of the board's 8-bit shift-register blocks.
- Recovers 8-bit frames from a single asynchronous line: idle-high, 1 start bit (0), 8 data bits, 1 stop bit (1).
- Bit order is selectable: LSB-first (UART style) or MSB-first.
- Presents each byte on a parallel bus with a one-cycle valid strobe, for LED/7-seg display logic on the FPGA board.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal values are even and >= 4.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- rx_in  input  1  asynchronous serial line, idle high.
- msb_first  input  1  0 = LSB-first, 1 = MSB-first; latched at start-bit detection.
- data_out  output  8  last correctly framed byte.
- data_valid  output  1  one-cycle pulse when data_out updates.
- frame_err  output  1  one-cycle pulse when the stop bit samples 0.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset is synchronous, active-high, on clk.
- Reset values: data_out=8'h00, data_valid=0, frame_err=0, busy=0, state=IDLE, bit counter=0, shift reg=0, both synchronizer flops=1.
- rx_in passes through a 2-flop synchronizer; rxs is the second flop. All decisions use rxs only.
- States are IDLE, START, DATA, STOP.
- IDLE:
  - Cycle D is the cycle with rxs==0. At D: clear the clk counter, latch msb_first, go to START.
- START:
  - At cycle D + CLKS_PER_BIT/2 (mid start bit), sample rxs.
  - rxs==0: go to DATA, clear the counter and bit index.
  - rxs==1: false start; go to IDLE with no strobe.
- DATA:
  - Data bit k (k=0..7) is sampled at D + CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT.
  - LSB-first shift: sh <= {rxs, sh[7:1]}.
  - MSB-first shift: sh <= {sh[6:0], rxs}.
  - After the k=7 sample, go to STOP.
- STOP:
  - Sample rxs at D + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT.
  - rxs==1: data_out <= sh and data_valid=1 on the next cycle.
  - rxs==0: frame_err=1 on the next cycle; data_out holds.
  - Either way, return to IDLE on that same next cycle.
- Re-arm: IDLE is re-entered at mid stop bit, so a start bit that immediately follows the stop bit is detected (back-to-back frames).
- data_valid and frame_err are never high together, and each is high for exactly 1 cycle per frame.
- msb_first changes mid-frame have no effect on the current frame.
- rxs glitches between sample points are ignored; there is exactly one sample per bit, with no majority vote.
- Reset mid-frame: the frame is abandoned, with no strobe. busy=0 on the cycle after reset is sampled. The next falling edge starts a fresh frame.
- Counters: the clk counter is $clog2(CLKS_PER_BIT) bits and saturates to nothing; it is cleared at every sample point. The bit index is 3 bits and does not wrap outside DATA.

Test Plan (CLKS_PER_BIT=16, rx_in driven in 16-cycle bit cells):
- Reset: hold reset for 3 cycles with rx_in toggling -> data_out=0x00, data_valid=0, frame_err=0, busy=0 throughout and one cycle after release.
- LSB-first frame 0xA5, msb_first=0 -> exactly one data_valid pulse, 153 cycles after the synchronized falling edge, with data_out=0xA5; frame_err stays 0; busy drops in the same cycle.
- Bit order: wire bits 0,0,0,0,0,0,0,1 sent with msb_first=0 -> 0x80. The same wire pattern with msb_first=1 -> 0x01. Toggling msb_first mid-frame does not change the result.
- False start: rx_in low for 4 cycles, then high -> busy high for about 8 cycles then 0; no data_valid and no frame_err; data_out unchanged.
- Framing error: 0x3C with stop bit 0 -> frame_err pulses once; data_valid stays 0; data_out keeps its prior value (0x01). A following good 0x5A frame -> data_out=0x5A.
- Robustness:
  - Reset asserted after 3 data bits of 0xFF -> no strobe.
  - Back-to-back frames 0x11 then 0x22 with no idle gap -> two data_valid pulses, values 0x11 then 0x22, exactly 160 cycles apart.
